// File: rtl/clkmon_pkg.sv
// Shared types and helpers for the clock monitor: FSM states, default
// parameter values and the tolerance check.
package clkmon_pkg;

  typedef enum logic [1:0] {StIdle, StArm, StHigh, StLow} state_e;

  localparam int unsigned DefCntW    = 16;
  localparam int unsigned DefExpOn   = 30;
  localparam int unsigned DefExpOff  = 70;
  localparam int unsigned DefTol     = 2;
  localparam int unsigned DefTimeout = 1000;

  // True when |diff| exceeds tol; diff arrives sign-extended from the caller.
  function automatic logic out_of_tol(input int diff, input int tol);
    int mag;
    mag = (diff < 0) ? -diff : diff;
    return mag > tol;
  endfunction

endpackage

// File: rtl/clkmon_edge_sync.sv
// Two-flop synchronizer plus history flop for the monitored clock; emits
// single-cycle rise/fall strobes with equal latency for both edges.
module clkmon_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  output logic rise,
  output logic fall
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic hist_q, hist_d;

  always_comb begin
    sync1_d = clk_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      hist_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      hist_q  <= hist_d;
    end
  end

  assign rise = sync2_q & ~hist_q;
  assign fall = ~sync2_q & hist_q;

endmodule

// File: rtl/clock_monitor.sv
// Measures high/low time and period of an asynchronous clock in clk cycles
// and flags duty/period errors. Define CLKMON_TIMEOUT_EN to build the stuck detector.
module clock_monitor
  import clkmon_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned EXP_ON  = DefExpOn,
  parameter int unsigned EXP_OFF = DefExpOff,
  parameter int unsigned TOL     = DefTol,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_enb,
  input  logic             clk_in,
  output logic             meas_valid,
  output logic [CNT_W-1:0] t_on,
  output logic [CNT_W-1:0] t_off,
  output logic [CNT_W:0]   period,
  output logic             duty_err,
  output logic             stuck
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W:0]   ExpOnX  = (CNT_W+1)'(EXP_ON);
  localparam logic [CNT_W:0]   ExpOffX = (CNT_W+1)'(EXP_OFF);

  logic rise, fall;

  clkmon_edge_sync u_edge_sync (
    .clk    (clk),
    .rst    (rst),
    .clk_in (clk_in),
    .rise   (rise),
    .fall   (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
  logic             sat_q, sat_d;
  logic [CNT_W-1:0] t_on_q, t_on_d;
  logic [CNT_W-1:0] t_off_q, t_off_d;
  logic [CNT_W:0]   period_q, period_d;
  logic             duty_err_q, duty_err_d;
  logic             meas_valid_q, meas_valid_d;

  logic signed [CNT_W:0] diff_on, diff_off;
  assign diff_on  = $signed({1'b0, on_cnt_q}) - $signed(ExpOnX);
  assign diff_off = $signed({1'b0, off_cnt_q}) - $signed(ExpOffX);

`ifdef CLKMON_TIMEOUT_EN
  localparam int unsigned      IdleW    = $clog2(TIMEOUT + 1);
  localparam logic [IdleW-1:0] TimeoutV = IdleW'(TIMEOUT);
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
  logic             stuck_q, stuck_d;
`endif

  always_comb begin
    state_d      = state_q;
    on_cnt_d     = on_cnt_q;
    off_cnt_d    = off_cnt_q;
    sat_d        = sat_q;
    t_on_d       = t_on_q;
    t_off_d      = t_off_q;
    period_d     = period_q;
    duty_err_d   = duty_err_q;
    meas_valid_d = 1'b0;
`ifdef CLKMON_TIMEOUT_EN
    idle_cnt_d   = idle_cnt_q;
    stuck_d      = stuck_q;
`endif

    if (!clk_enb) begin
      // Disabling drops any partial measurement but keeps published results.
      state_d   = StIdle;
      on_cnt_d  = '0;
      off_cnt_d = '0;
      sat_d     = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          on_cnt_d  = '0;
          off_cnt_d = '0;
          sat_d     = 1'b0;
          state_d   = StArm;
        end
        StArm: begin
          if (rise) begin
            state_d   = StHigh;
            on_cnt_d  = CNT_W'(1);
            off_cnt_d = '0;
            sat_d     = 1'b0;
          end
        end
        StHigh: begin
          if (fall) begin
            state_d   = StLow;
            off_cnt_d = CNT_W'(1);
          end else if (on_cnt_q == CntMax) begin
            sat_d = 1'b1;
          end else begin
            on_cnt_d = on_cnt_q + 1'b1;
          end
        end
        StLow: begin
          if (rise) begin
            t_on_d       = on_cnt_q;
            t_off_d      = off_cnt_q;
            period_d     = {1'b0, on_cnt_q} + {1'b0, off_cnt_q};
            duty_err_d   = sat_q
                         | out_of_tol(int'(diff_on), int'(TOL))
                         | out_of_tol(int'(diff_off), int'(TOL));
            meas_valid_d = 1'b1;
            state_d      = StHigh;
            on_cnt_d     = CNT_W'(1);
            off_cnt_d    = '0;
            sat_d        = 1'b0;
          end else if (off_cnt_q == CntMax) begin
            sat_d = 1'b1;
          end else begin
            off_cnt_d = off_cnt_q + 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end

`ifdef CLKMON_TIMEOUT_EN
    if (!clk_enb || state_q == StIdle) begin
      idle_cnt_d = '0;
      stuck_d    = stuck_q & clk_enb;
    end else if (rise || fall) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q + 1'b1 == TimeoutV) begin
      // No edge for TIMEOUT cycles: flag it and re-arm on the next rise.
      idle_cnt_d = '0;
      stuck_d    = 1'b1;
      state_d    = StArm;
      on_cnt_d   = '0;
      off_cnt_d  = '0;
      sat_d      = 1'b0;
    end else begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    if (meas_valid_d) begin
      stuck_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      on_cnt_q     <= '0;
      off_cnt_q    <= '0;
      sat_q        <= 1'b0;
      t_on_q       <= '0;
      t_off_q      <= '0;
      period_q     <= '0;
      duty_err_q   <= 1'b0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      on_cnt_q     <= on_cnt_d;
      off_cnt_q    <= off_cnt_d;
      sat_q        <= sat_d;
      t_on_q       <= t_on_d;
      t_off_q      <= t_off_d;
      period_q     <= period_d;
      duty_err_q   <= duty_err_d;
      meas_valid_q <= meas_valid_d;
    end
  end

`ifdef CLKMON_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      stuck_q    <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      stuck_q    <= stuck_d;
    end
  end
  assign stuck = stuck_q;
`else
  assign stuck = 1'b0;
`endif

  assign meas_valid = meas_valid_q;
  assign t_on       = t_on_q;
  assign t_off      = t_off_q;
  assign period     = period_q;
  assign duty_err   = duty_err_q;

endmodule

// File: tb/tb_clock_monitor.sv
// Randomized bench for clock_monitor: a 16-bit and an 8-bit instance share
// stimulus and are checked against a phase-length reference model.
module tb_clock_monitor;

  localparam int ExpOn   = 30;
  localparam int ExpOff  = 70;
  localparam int Tol     = 2;
  localparam int Timeout = 1000;

  logic clk = 1'b0;
  logic rst, clk_enb, clk_in;

  logic        mv_a, err_a, stuck_a;
  logic [15:0] ton_a, toff_a;
  logic [16:0] per_a;
  logic        mv_b, err_b, stuck_b;
  logic [7:0]  ton_b, toff_b;
  logic [8:0]  per_b;

  clock_monitor u_dut_a (
    .clk        (clk),
    .rst        (rst),
    .clk_enb    (clk_enb),
    .clk_in     (clk_in),
    .meas_valid (mv_a),
    .t_on       (ton_a),
    .t_off      (toff_a),
    .period     (per_a),
    .duty_err   (err_a),
    .stuck      (stuck_a)
  );

  clock_monitor #(.CNT_W(8)) u_dut_b (
    .clk        (clk),
    .rst        (rst),
    .clk_enb    (clk_enb),
    .clk_in     (clk_in),
    .meas_valid (mv_b),
    .t_on       (ton_b),
    .t_off      (toff_b),
    .period     (per_b),
    .duty_err   (err_b),
    .stuck      (stuck_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    else n_pass++;
  endtask

  // Reference model: phase lengths in clk cycles.
  function automatic int sat_of(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  function automatic int abs_of(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int err_of(input int h, input int l, input int w);
    int mx;
    mx = (1 << w) - 1;
    return int'((h > mx) || (l > mx) || (abs_of(h - ExpOn) > Tol) || (abs_of(l - ExpOff) > Tol));
  endfunction

  int   q_h[$], q_l[$], q_cyc[$];
  bit   m_enb = 1'b0;
  logic prev_lvl = 1'b0;
  int   last_h = -1, last_l = -1;
  int   pub_h = 0, pub_l = 0;
  bit   pub_any = 1'b0;

  task automatic invalidate();
    last_h = -1;
    last_l = -1;
  endtask

  // Drive clk_in at lvl for n cycles and update the model.
  task automatic phase(input logic lvl, input int n);
    if (lvl != prev_lvl) begin
      if (lvl) begin
        if (m_enb) begin
          if (last_h >= 0 && last_l >= 0) begin
            q_h.push_back(last_h);
            q_l.push_back(last_l);
            q_cyc.push_back(cyc + 3);
            pub_h   = last_h;
            pub_l   = last_l;
            pub_any = 1'b1;
          end
          last_h = n;
          last_l = -1;
        end
      end else if (last_h >= 0) begin
        last_l = n;
      end
    end else begin
      if (lvl && last_h >= 0 && last_l < 0) last_h += n;
      else if (!lvl && last_l >= 0) last_l += n;
    end
`ifdef CLKMON_TIMEOUT_EN
    if (n >= Timeout) invalidate();
`endif
    prev_lvl = lvl;
    clk_in   = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_enb(input logic v);
    clk_enb = v;
    m_enb   = v;
    invalidate();
  endtask

  task automatic check_hold(input string tag);
    check({tag, "_mv"}, mv_a, 0);
    check({tag, "_ton16"}, ton_a, sat_of(pub_h, 16));
    check({tag, "_toff16"}, toff_a, sat_of(pub_l, 16));
    check({tag, "_per16"}, per_a, sat_of(pub_h, 16) + sat_of(pub_l, 16));
    check({tag, "_err16"}, err_a, pub_any ? err_of(pub_h, pub_l, 16) : 0);
    check({tag, "_ton8"}, ton_b, sat_of(pub_h, 8));
    check({tag, "_err8"}, err_b, pub_any ? err_of(pub_h, pub_l, 8) : 0);
`ifndef CLKMON_TIMEOUT_EN
    check({tag, "_stuck"}, stuck_a, 0);
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    invalidate();
    pub_h   = 0;
    pub_l   = 0;
    pub_any = 1'b0;
    check_hold("reset");
    check("reset_per8", per_b, 0);
  endtask

  // Every published measurement is matched against the model queue.
  always @(negedge clk) begin : monitor
    int h, l, c;
    if (mv_a) begin
      if (q_h.size() == 0) begin
        check("spurious_pulse", 1, 0);
      end else begin
        h = q_h.pop_front();
        l = q_l.pop_front();
        c = q_cyc.pop_front();
        check("pulse_cycle", cyc, c);
        check("ton16", ton_a, sat_of(h, 16));
        check("toff16", toff_a, sat_of(l, 16));
        check("per16", per_a, sat_of(h, 16) + sat_of(l, 16));
        check("err16", err_a, err_of(h, l, 16));
        check("mv8", mv_b, 1);
        check("ton8", ton_b, sat_of(h, 8));
        check("toff8", toff_b, sat_of(l, 8));
        check("per8", per_b, sat_of(h, 8) + sat_of(l, 8));
        check("err8", err_b, err_of(h, l, 8));
        check("stuck_at_pulse", stuck_a, 0);
      end
    end else if (mv_b) begin
      check("pulse8_only", 1, 0);
    end
  end

  int hs[6] = '{35, 32, 33, 28, 27, 30};
  int ls[6] = '{65, 68, 70, 72, 73, 70};

  initial begin
    rst     = 1'b1;
    clk_enb = 1'b0;
    clk_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_hold("por");
    check("por_per8", per_b, 0);
    check("por_stuck8", stuck_b, 0);
    rst = 1'b0;

    // Nominal 30/70
    set_enb(1'b1);
    phase(1'b0, 10);
    repeat (4) begin
      phase(1'b1, 30);
      phase(1'b0, 70);
    end
    phase(1'b1, 30);
    check_hold("nominal");

    // Tolerance boundaries
    phase(1'b0, 70);
    foreach (hs[i]) begin
      phase(1'b1, hs[i]);
      phase(1'b0, ls[i]);
    end

    // Random periods around nominal
    for (int i = 0; i < 20; i++) begin
      phase(1'b1, int'($urandom_range(25, 35)));
      phase(1'b0, int'($urandom_range(64, 76)));
    end

    // Enable drop mid-high
    phase(1'b1, 30);
    phase(1'b0, 70);
    phase(1'b1, 10);
    set_enb(1'b0);
    check_hold("enb_drop");
    phase(1'b1, 10);
    check_hold("disabled");
    set_enb(1'b1);
    phase(1'b1, 10);
    phase(1'b0, 70);
    phase(1'b1, 30);
    check_hold("rearm");
    phase(1'b0, 70);
    phase(1'b1, 30);
    phase(1'b0, 70);

    // Reset mid-low
    phase(1'b1, 30);
    phase(1'b0, 30);
    do_reset();
    phase(1'b0, 40);
    phase(1'b1, 30);
    phase(1'b0, 70);
    phase(1'b1, 30);
    phase(1'b0, 70);

    // Saturation of the 8-bit instance, on each phase
    phase(1'b1, 300);
    phase(1'b0, 20);
    phase(1'b1, 30);
    phase(1'b0, 300);
    phase(1'b1, 30);
    phase(1'b0, 70);
    phase(1'b1, 30);
    check_hold("after_sat");
    phase(1'b0, 70);

`ifdef CLKMON_TIMEOUT_EN
    phase(1'b1, 1200);
    check("stuck16", stuck_a, 1);
    check("stuck8", stuck_b, 1);
    phase(1'b0, 70);
    phase(1'b1, 30);
    phase(1'b0, 70);
    phase(1'b1, 30);
    check("stuck_cleared", stuck_a, 0);
    phase(1'b0, 70);
`endif

    phase(1'b1, 30);
    phase(1'b0, 20);
    check("pending_pulses", q_h.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
